// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module  : uart_rx_pkg
// Purpose : Shared UART receive constants, FSM state encoding, parity helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 115200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Purpose : Two-flop synchronizer for the idle-high serial line (resets to 1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Purpose : UART receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN defined),
//           byte delivered on a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_bad;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx),
    .sync_o  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  assign par_bad = (par_bit_q != even_parity(shift_q));
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
`endif

    // Consume first, so a byte completing in the same cycle can refill the slot.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == LAST_CNT) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (par_bad) begin
            parity_err_d = 1'b1;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
          end else begin
            data_d     = shift_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Purpose : Directed self-checking bench for uart_rx at 10 clocks per bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int errors = 0;
  int checks = 0;

  // Event monitors, sampled on the falling edge.
  int         accept_cnt = 0;
  int         ferr_cnt   = 0;
  int         ovr_cnt    = 0;
  int         perr_cnt   = 0;
  logic [7:0] last_data  = 8'h00;

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      accept_cnt <= accept_cnt + 1;
      last_data  <= data;
    end
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (use_par) send_bit(par_bit);
    send_bit(stop_bit);
    rx = 1'b1;
    tick(20);
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  localparam logic USE_PAR =
`ifdef UART_RX_PARITY_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    tick(3);
    rst = 1'b0;
    tick(3);
    settle();
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(data), 32'h00);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    check("reset_perr", 32'(parity_err), 32'd0);

    // 1: good frame 0xA5 (even parity of A5 is 0)
    send_frame(8'hA5, 1'b1, USE_PAR, 1'b0);
    settle();
    check("t1_accepts", 32'(accept_cnt), 32'd1);
    check("t1_data", 32'(last_data), 32'hA5);
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    check("t1_ovr", 32'(ovr_cnt), 32'd0);
    check("t1_perr", 32'(perr_cnt), 32'd0);

    // 2: 0x3C with low stop bit, then good 0x5A
    send_frame(8'h3C, 1'b0, USE_PAR, 1'b0);
    settle();
    check("t2_ferr_pulse", 32'(ferr_cnt), 32'd1);
    check("t2_no_accept", 32'(accept_cnt), 32'd1);
    check("t2_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h5A, 1'b1, USE_PAR, 1'b0);
    settle();
    check("t2_accepts", 32'(accept_cnt), 32'd2);
    check("t2_data", 32'(last_data), 32'h5A);

    // 3: short glitch on the line
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    settle();
    check("t3_accepts", 32'(accept_cnt), 32'd2);
    check("t3_ferr", 32'(ferr_cnt), 32'd1);
    check("t3_valid", 32'(rx_valid), 32'd0);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h00, 1'b1, USE_PAR, 1'b0);
    settle();
    check("t4_valid1", 32'(rx_valid), 32'd1);
    check("t4_data1", 32'(data), 32'h00);
    send_frame(8'hFF, 1'b1, USE_PAR, 1'b0);
    settle();
    check("t4_ovr_pulse", 32'(ovr_cnt), 32'd1);
    check("t4_data_held", 32'(data), 32'h00);
    check("t4_valid_held", 32'(rx_valid), 32'd1);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    settle();
    check("t4_valid_clr", 32'(rx_valid), 32'd0);
    check("t4_accept", 32'(accept_cnt), 32'd3);
    check("t4_acc_data", 32'(last_data), 32'h00);

    // 5: reset in the middle of a frame while a byte is pending
    rx_ready = 1'b0;
    send_frame(8'h66, 1'b1, USE_PAR, 1'b0);
    settle();
    check("t5_pre_data", 32'(data), 32'h66);
    tick(1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    settle();
    check("t5_rst_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_data", 32'(data), 32'h00);
    tick(1);
    rst = 1'b0;
    rx_ready = 1'b1;
    tick(20);
    settle();
    check("t5_idle_valid", 32'(rx_valid), 32'd0);
    tick(1);
    send_frame(8'h81, 1'b1, USE_PAR, 1'b0);
    settle();
    check("t5_accepts", 32'(accept_cnt), 32'd4);
    check("t5_data", 32'(last_data), 32'h81);
    check("t5_ferr", 32'(ferr_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 6: parity error then good parity for 0x01
    tick(1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    settle();
    check("t6_perr_pulse", 32'(perr_cnt), 32'd1);
    check("t6_no_accept", 32'(accept_cnt), 32'd4);
    tick(1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    settle();
    check("t6_accepts", 32'(accept_cnt), 32'd5);
    check("t6_data", 32'(last_data), 32'h01);
    check("t6_perr_once", 32'(perr_cnt), 32'd1);
`else
    settle();
    check("no_parity_tied", 32'(parity_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
